camera_pixel_packer: RTL

//   Parametrised successor to the RGB565 capture path. Consumes a clk-domain byte stream
//   {vsync, hsync, data} (post clock-crossing FIFO) under valid/ready and packs BYTES_PER_PIX

---
 rtl/camera_pixel_packer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/camera_pixel_packer.sv
// Packs BYTES_PER_PIX camera beats per pixel, flags SOF/EOL, reports frame end and bad lines; CAM_CROP_EN adds a crop window.
// Latency 1 clk from last beat accept to out_valid; in_ready = !out_valid | out_ready (one-deep output stage, no loss).
module camera_pixel_packer #(
    parameter int IN_W          = 8,
    parameter int BYTES_PER_PIX = 2,
    parameter int LINE_COLS     = 640,
    parameter int COL_W         = 11,
    parameter int ROW_W         = 10,
    parameter int MSB_FIRST     = 0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_vsync,
    input  logic                          in_hsync,
    input  logic [IN_W-1:0]               in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [IN_W*BYTES_PER_PIX-1:0] out_data,
    output logic                          out_sof,
    output logic                          out_eol,
`ifdef CAM_CROP_EN
    input  logic [COL_W-1:0]              crop_x0,
    input  logic [COL_W-1:0]              crop_x1,
    input  logic [ROW_W-1:0]              crop_y0,
    input  logic [ROW_W-1:0]              crop_y1,
`endif
    output logic                          frame_done,
    output logic                          line_err
);

    localparam int OUT_W = IN_W * BYTES_PER_PIX;
    localparam int PH_W  = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(BYTES_PER_PIX - 1);
    localparam logic [COL_W-1:0] COLS     = COL_W'(LINE_COLS);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_COLS - 1);
    localparam logic [COL_W-1:0] COL_MAX  = {COL_W{1'b1}};

    logic [PH_W-1:0]  phase;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             last_vsync;
    logic             last_hsync;
    logic             sof_pending;
    logic [IN_W-1:0]  beats [BYTES_PER_PIX];

    logic             accept;
    logic             active;
    logic             vs_rise;
    logic             vs_fall;
    logic             hs_fall;
    logic [PH_W-1:0]  phase_eff;
    logic [COL_W-1:0] col_eff;
    logic [COL_W-1:0] col_inc;
    logic             pix_done;
    logic             in_win;
    logic             eol_hit;
    logic             load;
    logic [OUT_W-1:0] pix_word;
    logic [IN_W-1:0]  beat_sel;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign active   = in_vsync && in_hsync;
    assign vs_rise  = in_vsync && !last_vsync;
    assign vs_fall  = !in_vsync && last_vsync;
    assign hs_fall  = !in_hsync && last_hsync;

    // A vsync rise restarts the frame on the same beat, so the beat itself sees cleared counters.
    assign phase_eff = (vs_rise || !active) ? '0 : phase;
    assign col_eff   = vs_rise ? '0 : col;
    assign col_inc   = (col_eff == COL_MAX) ? col_eff : col_eff + 1'b1;
    assign pix_done  = accept && active && (phase_eff == PH_LAST);
    assign load      = pix_done && in_win;

`ifdef CAM_CROP_EN
    logic [ROW_W-1:0] row_eff;
    assign row_eff = vs_rise ? '0 : row;
    assign in_win  = (col_eff >= crop_x0) && (col_eff <= crop_x1) &&
                     (row_eff >= crop_y0) && (row_eff <= crop_y1);
    assign eol_hit = (col_eff == crop_x1);
`else
    assign in_win  = 1'b1;
    assign eol_hit = (col_eff == COL_LAST);
`endif

    // The current beat completes the pixel, so it is spliced in combinationally rather than read back.
    always_comb begin
        pix_word = '0;
        beat_sel = '0;
        for (int i = 0; i < BYTES_PER_PIX; i++) begin
            beat_sel = (PH_W'(i) == phase_eff) ? in_data : beats[i];
            if (MSB_FIRST != 0) begin
                pix_word[(BYTES_PER_PIX-1-i)*IN_W +: IN_W] = beat_sel;
            end else begin
                pix_word[i*IN_W +: IN_W] = beat_sel;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase       <= '0;
            col         <= '0;
            row         <= '0;
            last_vsync  <= 1'b0;
            last_hsync  <= 1'b0;
            sof_pending <= 1'b0;
            for (int i = 0; i < BYTES_PER_PIX; i++) begin
                beats[i] <= '0;
            end
        end else if (accept) begin
            last_vsync <= in_vsync;
            last_hsync <= in_hsync;

            if (active) begin
                beats[phase_eff] <= in_data;
                phase <= (phase_eff == PH_LAST) ? '0 : phase_eff + 1'b1;
            end else begin
                phase <= '0;
            end

            if (hs_fall || (vs_rise && !pix_done)) begin
                col <= '0;
            end else if (pix_done) begin
                col <= col_inc;
            end

            if (vs_fall || vs_rise) begin
                row <= '0;
            end else if (hs_fall) begin
                row <= row + 1'b1;
            end

            if (load) begin
                sof_pending <= 1'b0;
            end else if (vs_rise) begin
                sof_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sof    <= 1'b0;
            out_eol    <= 1'b0;
            frame_done <= 1'b0;
            line_err   <= 1'b0;
        end else begin
            frame_done <= accept && vs_fall;
            line_err   <= accept && hs_fall && ((col != COLS) || (phase != '0));
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= pix_word;
                out_sof   <= sof_pending || vs_rise;
                out_eol   <= eol_hit;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
